systolic_array_out_drain_ctrl: RTL

Controller that sequences the systolic array's N per-row output FIFOs. It accepts tagged result values from the array, routes each value into its row's output FIFO by pulsing that row's shift, and counts fills per row. Once every row holds N values, it presents the completed result tile to writeback one row at a time over a valid/ready handshake. It sits between the array's result port and the output FIFO bank, and feeds the writeback/memory path.

---
 rtl/sys_arr_pkg.sv | 14 +
 rtl/out_fill_tracker.sv | 32 +++
 rtl/systolic_array_out_drain_ctrl.sv | 88 ++++++++
 3 files changed

// File: rtl/sys_arr_pkg.sv
// sys_arr_pkg: shared systolic-array parameters, drain FSM state type and width helpers
package sys_arr_pkg;
  localparam int N = 4;
  localparam int DW = 16;
  function automatic int row_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
  localparam int ROW_W = row_w(N);
  localparam int CNT_W = cnt_w(N);
  typedef enum logic {FILL, DRAIN} drain_state_t;
endpackage

// File: rtl/out_fill_tracker.sv
// out_fill_tracker: per-row fill counters for the output FIFO bank
// Ports: clk, rst (sync, active-high), clr (zero all counters), inc (per-row increment),
//        full (row currently holds N words), all_full (every row holds N words after this edge)
module out_fill_tracker
  import sys_arr_pkg::*;
#(
  parameter int N = sys_arr_pkg::N,
  localparam int CW = cnt_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [N-1:0] inc,
  output logic [N-1:0] full,
  output logic         all_full
);
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  // all_full looks at next-state counts so the final shift and the FILL->DRAIN move share an edge
  always_comb begin
    all_full = 1'b1;
    for (int r = 0; r < N; r++) begin
      cnt_d[r] = clr ? '0 : cnt_q[r] + CW'(inc[r]);
      full[r] = cnt_q[r] == CW'(N);
      all_full = all_full & (cnt_d[r] == CW'(N));
    end
  end
  always_ff @(posedge clk) begin
    if (rst) for (int r = 0; r < N; r++) cnt_q[r] <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/systolic_array_out_drain_ctrl.sv
// systolic_array_out_drain_ctrl: routes array results into per-row output FIFOs, then drains the tile row by row
// Ports: clk, rst (sync, active-high), flush (abort tile)
//        res_valid/res_ready/res_row/res_data : result stream from the array
//        fifo_shift/fifo_shift_value/fifo_out : output FIFO bank control and contents
//        wb_valid/wb_ready/wb_row/wb_data     : row-wise writeback handshake
//        tile_done                           : pulse after the last row is accepted
//        err (only with OUT_DRAIN_ERR_CHECK_EN): sticky dropped-word flag
module systolic_array_out_drain_ctrl
  import sys_arr_pkg::*;
#(
  parameter int N = sys_arr_pkg::N,
  parameter int DW = sys_arr_pkg::DW,
  localparam int RW = row_w(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [RW-1:0]     res_row,
  input  logic [DW-1:0]     res_data,
  output logic [N-1:0]      fifo_shift,
  output logic [DW-1:0]     fifo_shift_value,
  input  logic [N*DW*N-1:0] fifo_out,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RW-1:0]     wb_row,
  output logic [DW*N-1:0]   wb_data,
  output logic              tile_done
`ifdef OUT_DRAIN_ERR_CHECK_EN
  ,
  output logic              err
`endif
);
  drain_state_t state_q, state_d;
  logic [RW-1:0] row_ptr_q, row_ptr_d;
  logic tile_done_q, tile_done_d;
  logic [N-1:0] full;
  logic all_full, row_ok, shift_en, hs, last, clr;
  assign row_ok = 32'(res_row) < N;
  assign shift_en = state_q == FILL && res_valid && !flush && row_ok && !full[res_row];
  assign hs = state_q == DRAIN && wb_ready && !flush;
  assign last = hs && row_ptr_q == RW'(N - 1);
  assign clr = flush || last;
  out_fill_tracker #(.N(N)) u_fill (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .inc      (fifo_shift),
    .full     (full),
    .all_full (all_full)
  );
  always_ff @(posedge clk) begin
    state_q <= rst ? FILL : state_d;
  end
  always_comb begin
    state_d = flush ? FILL : state_q == FILL ? (all_full ? DRAIN : FILL) : (last ? FILL : DRAIN);
  end
  always_comb begin
    res_ready = state_q == FILL;
    wb_valid = state_q == DRAIN;
    fifo_shift = shift_en ? N'(1) << res_row : '0;
  end
  assign fifo_shift_value = res_data;
  assign row_ptr_d = clr ? '0 : hs ? row_ptr_q + 1'b1 : row_ptr_q;
  assign tile_done_d = last;
  always_ff @(posedge clk) begin
    if (rst) begin
      row_ptr_q <= '0;
      tile_done_q <= 1'b0;
    end else begin
      row_ptr_q <= row_ptr_d;
      tile_done_q <= tile_done_d;
    end
  end
  assign wb_row = row_ptr_q;
  assign wb_data = fifo_out[int'(row_ptr_q) * (DW * N) +: DW * N];
  assign tile_done = tile_done_q;
`ifdef OUT_DRAIN_ERR_CHECK_EN
  logic err_q, err_d;
  // any FILL word that is offered but not shifted was dropped (bad row or row already full)
  assign err_d = err_q | (state_q == FILL && res_valid && !flush && !shift_en);
  always_ff @(posedge clk) begin
    err_q <= rst ? 1'b0 : err_d;
  end
  assign err = err_q;
`endif
endmodule
